rr_arbiter8: RTL and testbench
==============================

Name: rr_arbiter8

Overview:
Round-robin arbiter that shares one resource (bus or datapath slot) among 8 requesters. It uses LSB-first priority encoding with a rotating mask, so no requester starves. Each grant is held until the requester releases it or a hold timeout forces rotation. It sits between the requester blocks and the shared resource, and its one-hot grant drives the resource's select mux.

Parameters:
N, 8, number of requesters (fixed at 8 in this revision)
IDXW, 3, width of the grant index
MAX_HOLD, 16, maximum consecutive grant cycles before forced release; 0 means unlimited

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
req  input  8  request vector, bit i = requester i; held high for as long as the grant is wanted
gnt  output  8  one-hot grant, all zero when idle
gnt_idx  output  3  binary index of the current grant; 0 when idle
gnt_valid  output  1  high while any grant is active (equals |gnt)
preempt  output  1  one-cycle pulse when a grant is revoked by timeout

Behaviour:
- All outputs are registered. rst_n is sampled only on the rising edge of clk.
- Reset values: gnt=0, gnt_idx=0, gnt_valid=0, preempt=0, ptr=7, hold_cnt=0, state=IDLE.
- Because ptr resets to 7, requester 0 has top priority after reset.
- Priority search: start at ptr+1 and go upward, wrapping modulo 8, ending at ptr itself.
  - Implementation: the masked vector is req & ~((2<<ptr)-1), truncated to 8 bits. If it is nonzero, encode it lowest-index-first. Otherwise encode the unmasked req lowest-index-first.
- State IDLE:
  - If req==0 at a clock edge, remain in IDLE.
  - Otherwise, at the same edge: load the winner into gnt/gnt_idx, set gnt_valid=1, hold_cnt=0, go to GRANT.
  - Latency from req sampled to gnt visible: 1 cycle.
- State GRANT, evaluated each edge in priority order:
  1. req[gnt_idx]==0 (release): clear gnt, gnt_idx and gnt_valid; set ptr=gnt_idx; go to IDLE.
  2. MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 (timeout): clear gnt, gnt_idx and gnt_valid; set ptr=gnt_idx; preempt=1 for exactly one cycle; go to IDLE.
  3. Otherwise: hold the grant and increment hold_cnt.
- On timeout, the preempted requester becomes lowest priority on the next arbitration.
- Every grant is followed by exactly one idle (turnaround) cycle with gnt=0. Back-to-back grants are not allowed.
- With MAX_HOLD=M, a grant lasts at most M cycles.
- Changes to other req bits during GRANT have no effect until the next arbitration.
- hold_cnt is $clog2(MAX_HOLD+1) bits wide and never wraps, because it is reset on every grant.
- Reset asserted mid-grant: the next edge forces all reset values regardless of state. No preempt pulse is issued.
- A requester that deasserts req while waiting (never granted) is simply not selected. No state is kept per requester.
- No X-propagation: gnt is never multi-hot, and gnt_valid==|gnt on every cycle.

Decomposition:
- Package rr_arb_pkg holds:
  - N and IDXW constants
  - state enum {IDLE, GRANT}
  - the reset value of ptr (7)
- Sub-module prio_enc8: combinational 8-bit lowest-index-first priority encoder with outputs idx[2:0] and valid.
  - Instantiated twice, once for the masked vector and once for the unmasked vector.
  - The top level selects the masked result when its valid is high.

Test Plan:
- Idle: after reset, req=8'h00 for 5 cycles -> gnt=8'h00, gnt_valid=0, gnt_idx=0, preempt=0 throughout.
- Single grant: req=8'b00000001 at edge k -> gnt=8'b00000001 and gnt_idx=0 after edge k. Drop req at edge k+3 -> gnt=0 after edge k+3.
- Rotation: req=8'b10000010 held, each requester drops its req 2 cycles after being granted then re-raises it.
  - Grant order: 1, idle, 7, idle, 1, ...
  - Each grant is preceded by exactly one gnt=0 cycle.
- Timeout (MAX_HOLD=4): req=8'b00000100 held constant.
  - gnt=8'b00000100 for exactly 4 cycles, then preempt=1 for one cycle with gnt=0.
  - The next cycle regrants index 2, since it is the only requester.
- Wrap-around: grant 6, then release (ptr=6). Present req=8'b01000001 -> next grant is 0, not 6. After 0 releases, 6 is granted.
- Reset mid-grant: gnt=8'b00001000 active, drive rst_n=0 for one edge.
  - After that edge: all outputs 0, preempt=0.
  - With req=8'b00001001 after reset release, the grant goes to 0 (ptr=7).

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared constants and state encoding for the 8-way round-robin arbiter.
package rr_arb_pkg;

  localparam int unsigned N    = 8;
  localparam int unsigned IDXW = 3;

  // Pointer reset value: the search starts at ptr+1, so requester 0 leads after reset.
  localparam logic [IDXW-1:0] PTR_RST = IDXW'(7);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-bit priority encoder; the lowest set bit wins.
module prio_enc8
  import rr_arb_pkg::*;
(
  input  logic [N-1:0]    vec,
  output logic [IDXW-1:0] idx,
  output logic            valid
);

  // Scan downward so that the lowest set index is the last assignment.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDXW'(i);
    end
  end

  assign valid = |vec;

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with a rotating mask, hold timeout
// and a mandatory idle turnaround cycle between grants.
module rr_arbiter8
  import rr_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_valid,
  output logic            preempt
);

  localparam int unsigned HCW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam int unsigned MW  = N + 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t          state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [HCW-1:0]  hold_q, hold_d;
  logic [N-1:0]    gnt_d;
  logic [IDXW-1:0] idx_d;
  logic            valid_d;
  logic            pre_d;

  logic [MW-1:0]   lowmask;
  logic [N-1:0]    masked;
  logic [IDXW-1:0] m_idx, u_idx, win_idx;
  logic            m_valid, u_valid;

  // Bits at or below ptr are masked off so the search starts just above ptr.
  assign lowmask = (MW'(2) << ptr_q) - MW'(1);
  assign masked  = req & ~lowmask[N-1:0];

  prio_enc8 u_enc_masked (
    .vec   (masked),
    .idx   (m_idx),
    .valid (m_valid)
  );

  prio_enc8 u_enc_plain (
    .vec   (req),
    .idx   (u_idx),
    .valid (u_valid)
  );

  assign win_idx = m_valid ? m_idx : u_idx;

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    gnt_d   = gnt;
    idx_d   = gnt_idx;
    valid_d = gnt_valid;
    pre_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (u_valid) begin
          gnt_d   = N'(1) << win_idx;
          idx_d   = win_idx;
          valid_d = 1'b1;
          hold_d  = '0;
          state_d = GRANT;
        end
      end

      GRANT: begin
        if (!req[gnt_idx]) begin
          gnt_d   = '0;
          idx_d   = '0;
          valid_d = 1'b0;
          ptr_d   = gnt_idx;
          state_d = IDLE;
        end else if ((MAX_HOLD != 0) && (hold_q == HOLD_LAST)) begin
          gnt_d   = '0;
          idx_d   = '0;
          valid_d = 1'b0;
          ptr_d   = gnt_idx;
          pre_d   = 1'b1;
          state_d = IDLE;
        end else begin
          hold_d = hold_q + HCW'(1);
        end
      end

      default: begin
        gnt_d   = '0;
        idx_d   = '0;
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= PTR_RST;
      hold_q    <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      preempt   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gnt       <= gnt_d;
      gnt_idx   <= idx_d;
      gnt_valid <= valid_d;
      preempt   <= pre_d;
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed scoreboard bench for rr_arbiter8 built with a 4-cycle hold limit.
module tb_rr_arbiter8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] g;
    logic       p;
  } exp_t;

  exp_t sb[$];

  rr_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] idx_of(input logic [7:0] g);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (g[i]) r = 3'(i);
    return r;
  endfunction

  // Drive req, queue the expected post-edge outputs, then compare 1ns after the edge.
  task automatic step(input logic [7:0] r, input logic [7:0] eg, input logic ep);
    exp_t e;
    req = r;
    sb.push_back('{g: eg, p: ep});
    @(posedge clk);
    #1;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL sb_empty: got size %0d expected nonzero", sb.size());
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      assert (gnt === e.g) else begin
        errors++;
        $error("FAIL gnt: got %h expected %h", gnt, e.g);
      end
      checks++;
      assert (gnt_idx === idx_of(e.g)) else begin
        errors++;
        $error("FAIL gnt_idx: got %0d expected %0d", gnt_idx, idx_of(e.g));
      end
      checks++;
      assert (gnt_valid === (|e.g)) else begin
        errors++;
        $error("FAIL gnt_valid: got %b expected %b", gnt_valid, |e.g);
      end
      checks++;
      assert (preempt === e.p) else begin
        errors++;
        $error("FAIL preempt: got %b expected %b", preempt, e.p);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;

    // Reset state
    step(8'h00, 8'h00, 1'b0);
    step(8'h00, 8'h00, 1'b0);
    rst_n = 1'b1;

    // Idle for 5 cycles
    for (int i = 0; i < 5; i++) step(8'h00, 8'h00, 1'b0);

    // Single grant to 0, dropped at the third edge after the grant
    step(8'h01, 8'h01, 1'b0);
    step(8'h01, 8'h01, 1'b0);
    step(8'h01, 8'h01, 1'b0);
    step(8'h00, 8'h00, 1'b0);

    // Rotation between 1 and 7 with one idle cycle between grants
    step(8'h82, 8'h02, 1'b0);
    step(8'h82, 8'h02, 1'b0);
    step(8'h80, 8'h00, 1'b0);
    step(8'h82, 8'h80, 1'b0);
    step(8'h82, 8'h80, 1'b0);
    step(8'h02, 8'h00, 1'b0);
    step(8'h82, 8'h02, 1'b0);
    step(8'h82, 8'h02, 1'b0);
    step(8'h00, 8'h00, 1'b0);

    // Timeout: 4 grant cycles, preempt pulse, then regrant of the lone requester
    step(8'h04, 8'h04, 1'b0);
    step(8'h04, 8'h04, 1'b0);
    step(8'h04, 8'h04, 1'b0);
    step(8'h04, 8'h04, 1'b0);
    step(8'h04, 8'h00, 1'b1);
    step(8'h04, 8'h04, 1'b0);
    step(8'h00, 8'h00, 1'b0);

    // Wrap-around: other req bits ignored mid-grant, then 0 wins over 6 after ptr=6
    step(8'h40, 8'h40, 1'b0);
    step(8'h7f, 8'h40, 1'b0);
    step(8'h00, 8'h00, 1'b0);
    step(8'h41, 8'h01, 1'b0);
    step(8'h41, 8'h01, 1'b0);
    step(8'h40, 8'h00, 1'b0);
    step(8'h40, 8'h40, 1'b0);
    step(8'h00, 8'h00, 1'b0);

    // Reset mid-grant, then ptr back at 7 so requester 0 wins
    step(8'h08, 8'h08, 1'b0);
    step(8'h08, 8'h08, 1'b0);
    rst_n = 1'b0;
    step(8'h08, 8'h00, 1'b0);
    rst_n = 1'b1;
    step(8'h09, 8'h01, 1'b0);
    step(8'h09, 8'h01, 1'b0);
    step(8'h08, 8'h00, 1'b0);
    step(8'h08, 8'h08, 1'b0);
    step(8'h00, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
